zap_wb_arbiter_n: RTL and testbench

Parametrised N-master Wishbone B3 arbiter that generalises the fixed 3-way TLB/tag/cache master mux in the ZAP cache top. It adds selectable fixed-priority or round-robin arbitration, optional bus lock for the full CYC duration, and a no-ACK timeout that returns a synthesised error to the stalled master. It sits between the cache sub-masters (cache FSM, tag RAM, TLB, optional extra masters such as a write buffer) and the shared external Wishbone port.

---
 rtl/zap_wb_pkg.sv | 10 +
 rtl/zap_wb_arbiter_n_if.sv | 46 ++++
 rtl/zap_wb_rr_pick.sv | 37 +++
 rtl/zap_wb_arbiter_n.sv | 104 ++++++++++
 tb/tb_zap_wb_arbiter_n.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/zap_wb_pkg.sv
// zap_wb_pkg: shared Wishbone constants and helpers for the N-master arbiter.
// Contents: CTI encodings and an index-width helper (at least 1 bit).
package zap_wb_pkg;
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_BURST   = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    function automatic int idx_wdt(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/zap_wb_arbiter_n_if.sv
// zap_wb_arbiter_n_if: bundle of the N-master request side and the shared Wishbone port.
// Master-side : i_wb_*_nxt packed per master, o_wb_ack/o_wb_err one-hot back.
// Bus-side    : o_wb_*_nxt combinational mux, o_wb_* registered, i_wb_dat/ack/err from the slave.
// Modports    : slave = arbiter view, master = environment (sub-masters + external slave) view.
interface zap_wb_arbiter_n_if #(
    parameter int NUM_MASTERS = 4,
    parameter int DATA_WDT    = 32,
    parameter int ADDR_WDT    = 32
);
    localparam int SEL_WDT = DATA_WDT / 8;
    logic [NUM_MASTERS-1:0]          i_wb_cyc_nxt, i_wb_stb_nxt, i_wb_wen_nxt;
    logic [NUM_MASTERS*SEL_WDT-1:0]  i_wb_sel_nxt;
    logic [NUM_MASTERS*DATA_WDT-1:0] i_wb_dat_nxt;
    logic [NUM_MASTERS*ADDR_WDT-1:0] i_wb_adr_nxt;
    logic [NUM_MASTERS*3-1:0]        i_wb_cti_nxt;
    logic [NUM_MASTERS-1:0]          o_wb_ack, o_wb_err;
    logic                            o_wb_cyc_nxt, o_wb_stb_nxt, o_wb_wen_nxt;
    logic [SEL_WDT-1:0]              o_wb_sel_nxt;
    logic [DATA_WDT-1:0]             o_wb_dat_nxt;
    logic [ADDR_WDT-1:0]             o_wb_adr_nxt;
    logic [2:0]                      o_wb_cti_nxt;
    logic                            o_wb_cyc, o_wb_stb, o_wb_wen;
    logic [SEL_WDT-1:0]              o_wb_sel;
    logic [DATA_WDT-1:0]             o_wb_dat;
    logic [ADDR_WDT-1:0]             o_wb_adr;
    logic [2:0]                      o_wb_cti;
    logic [DATA_WDT-1:0]             i_wb_dat;
    logic                            i_wb_ack, i_wb_err;
    // Read data fans out to the masters directly, so the arbiter never sees it.
    modport slave (
        input  i_wb_cyc_nxt, i_wb_stb_nxt, i_wb_wen_nxt, i_wb_sel_nxt, i_wb_dat_nxt,
               i_wb_adr_nxt, i_wb_cti_nxt, i_wb_ack, i_wb_err,
        output o_wb_ack, o_wb_err,
               o_wb_cyc_nxt, o_wb_stb_nxt, o_wb_wen_nxt, o_wb_sel_nxt, o_wb_dat_nxt,
               o_wb_adr_nxt, o_wb_cti_nxt,
               o_wb_cyc, o_wb_stb, o_wb_wen, o_wb_sel, o_wb_dat, o_wb_adr, o_wb_cti
    );
    modport master (
        output i_wb_cyc_nxt, i_wb_stb_nxt, i_wb_wen_nxt, i_wb_sel_nxt, i_wb_dat_nxt,
               i_wb_adr_nxt, i_wb_cti_nxt, i_wb_ack, i_wb_err, i_wb_dat,
        input  o_wb_ack, o_wb_err,
               o_wb_cyc_nxt, o_wb_stb_nxt, o_wb_wen_nxt, o_wb_sel_nxt, o_wb_dat_nxt,
               o_wb_adr_nxt, o_wb_cti_nxt,
               o_wb_cyc, o_wb_stb, o_wb_wen, o_wb_sel, o_wb_dat, o_wb_adr, o_wb_cti
    );
endinterface

// File: rtl/zap_wb_rr_pick.sv
// zap_wb_rr_pick: combinational winner picker, fixed priority or round-robin.
// Ports: req (request vector), last (current owner), rr_en (1 = round-robin),
//        win (winning index), valid (any request present).
module zap_wb_rr_pick
    import zap_wb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_wdt(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    input  logic          rr_en,
    output logic [IW-1:0] win,
    output logic          valid
);
    logic [IW-1:0] fix, lo, hi;
    logic          hi_vld;
    // fix: highest requester. lo: lowest requester. hi: lowest requester above last,
    // which is where the round-robin search lands before wrapping around to lo.
    always_comb begin
        fix    = '0;
        lo     = '0;
        hi     = '0;
        hi_vld = 1'b0;
        for (int k = 0; k < N; k++)
            if (req[k]) fix = IW'(k);
        for (int k = N - 1; k >= 0; k--) begin
            if (req[k]) lo = IW'(k);
            if (req[k] && k > int'(last)) begin
                hi     = IW'(k);
                hi_vld = 1'b1;
            end
        end
    end
    assign win   = !rr_en ? fix : hi_vld ? hi : lo;
    assign valid = |req;
endmodule

// File: rtl/zap_wb_arbiter_n.sv
// zap_wb_arbiter_n: N-master Wishbone B3 arbiter with fixed/round-robin priority, optional lock and no-ACK timeout.
// Ports: i_clk, i_reset (sync, active-high); wb (slave modport: master requests in,
//        muxed and registered bus out, ACK/ERR routed back); o_grant (one-hot owner of
//        the registered strobe); o_timeout (pulse in the cycle a forced error is returned).
module zap_wb_arbiter_n
    import zap_wb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int DATA_WDT    = 32,
    parameter int ADDR_WDT    = 32,
    parameter int RR_EN       = 0,
    parameter int LOCK_EN     = 0,
    parameter int TIMEOUT     = 0
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    zap_wb_arbiter_n_if.slave      wb,
    output logic [NUM_MASTERS-1:0] o_grant,
    output logic                   o_timeout
);
    localparam int IW = idx_wdt(NUM_MASTERS);
    localparam int SW = DATA_WDT / 8;
    logic [IW-1:0] grant_ff, grant_nxt, win;
    logic          valid, tmo_fire, bnd;

    zap_wb_rr_pick #(.N(NUM_MASTERS), .IW(IW)) u_pick (
        .req   (wb.i_wb_cyc_nxt),
        .last  (grant_ff),
        .rr_en (RR_EN != 0),
        .win   (win),
        .valid (valid)
    );

    generate
        if (TIMEOUT > 0) begin : g_tmo
            localparam int TW = $clog2(TIMEOUT + 1);
            logic [TW-1:0] tmo_cnt;
            // A real ACK/ERR in the final cycle suppresses the forced error.
            assign tmo_fire = (tmo_cnt == TW'(TIMEOUT - 1)) & wb.o_wb_stb & !wb.i_wb_ack & !wb.i_wb_err;
            always_ff @(posedge i_clk)
                tmo_cnt <= (i_reset | !wb.o_wb_stb | wb.i_wb_ack | wb.i_wb_err | tmo_fire) ? '0 : tmo_cnt + TW'(1);
        end else begin : g_no_tmo
            assign tmo_fire = 1'b0;
        end
    endgenerate

    // Re-arbitrate only when the registered strobe is idle or retiring; under lock the
    // owner must also have released its cycle.
    assign bnd       = (!wb.o_wb_stb | wb.i_wb_ack | wb.i_wb_err | tmo_fire) &
                       ((LOCK_EN == 0) | !wb.i_wb_cyc_nxt[grant_ff]);
    assign grant_nxt = (bnd & valid) ? win : grant_ff;
    assign o_timeout = tmo_fire & !i_reset;

    always_comb begin
        wb.o_wb_cyc_nxt = 1'b0;
        wb.o_wb_stb_nxt = 1'b0;
        wb.o_wb_wen_nxt = 1'b0;
        wb.o_wb_sel_nxt = '0;
        wb.o_wb_dat_nxt = '0;
        wb.o_wb_adr_nxt = '0;
        wb.o_wb_cti_nxt = CTI_EOB;
        wb.o_wb_ack     = '0;
        wb.o_wb_err     = '0;
        o_grant         = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (grant_nxt == IW'(k)) begin
                wb.o_wb_cyc_nxt = wb.i_wb_cyc_nxt[k];
                wb.o_wb_stb_nxt = wb.i_wb_stb_nxt[k];
                wb.o_wb_wen_nxt = wb.i_wb_wen_nxt[k];
                wb.o_wb_sel_nxt = wb.i_wb_sel_nxt[k*SW +: SW];
                wb.o_wb_dat_nxt = wb.i_wb_dat_nxt[k*DATA_WDT +: DATA_WDT];
                wb.o_wb_adr_nxt = wb.i_wb_adr_nxt[k*ADDR_WDT +: ADDR_WDT];
                wb.o_wb_cti_nxt = wb.i_wb_cti_nxt[k*3 +: 3];
            end
            if (grant_ff == IW'(k)) begin
                wb.o_wb_ack[k] = wb.i_wb_ack & !i_reset;
                wb.o_wb_err[k] = (wb.i_wb_err | tmo_fire) & !i_reset;
                o_grant[k]     = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            grant_ff    <= '0;
            wb.o_wb_cyc <= 1'b0;
            wb.o_wb_stb <= 1'b0;
            wb.o_wb_wen <= 1'b0;
            wb.o_wb_sel <= '0;
            wb.o_wb_dat <= '0;
            wb.o_wb_adr <= '0;
            wb.o_wb_cti <= CTI_EOB;
        end else begin
            grant_ff    <= grant_nxt;
            wb.o_wb_cyc <= wb.o_wb_cyc_nxt;
            wb.o_wb_stb <= wb.o_wb_stb_nxt;
            wb.o_wb_wen <= wb.o_wb_wen_nxt;
            wb.o_wb_sel <= wb.o_wb_sel_nxt;
            wb.o_wb_dat <= wb.o_wb_dat_nxt;
            wb.o_wb_adr <= wb.o_wb_adr_nxt;
            wb.o_wb_cti <= wb.o_wb_cti_nxt;
        end
    end
endmodule

// File: tb/tb_zap_wb_arbiter_n.sv
// tb_zap_wb_arbiter_n: directed checks of three arbiter configurations sharing one stimulus.
// dut_a: fixed priority, no lock, TIMEOUT=8. dut_b: round-robin. dut_c: fixed priority with lock.
module tb_zap_wb_arbiter_n;
    import zap_wb_pkg::*;
    logic         i_clk = 1'b0;
    logic         i_reset = 1'b1;
    logic [3:0]   cyc = '0, stb = '0, wen = 4'b0101;
    logic [15:0]  sel = 16'hffff;
    logic [127:0] dat = {32'hd3d3d3d3, 32'hd2d2d2d2, 32'hd1d1d1d1, 32'hd0d0d0d0};
    logic [127:0] adr = {32'ha0000003, 32'ha0000002, 32'ha0000001, 32'ha0000000};
    logic [11:0]  cti = {4{CTI_EOB}};
    logic         ack = 1'b0, err = 1'b0;
    logic [3:0]   grant_a, grant_b, grant_c;
    logic         tmo_a, tmo_b, tmo_c;
    int           checks = 0, errors = 0;

    always #5 i_clk = ~i_clk;

    zap_wb_arbiter_n_if bus_a ();
    zap_wb_arbiter_n_if bus_b ();
    zap_wb_arbiter_n_if bus_c ();

    assign bus_a.i_wb_cyc_nxt = cyc; assign bus_a.i_wb_stb_nxt = stb; assign bus_a.i_wb_wen_nxt = wen;
    assign bus_a.i_wb_sel_nxt = sel; assign bus_a.i_wb_dat_nxt = dat; assign bus_a.i_wb_adr_nxt = adr;
    assign bus_a.i_wb_cti_nxt = cti; assign bus_a.i_wb_ack = ack; assign bus_a.i_wb_err = err;
    assign bus_a.i_wb_dat = 32'h0;
    assign bus_b.i_wb_cyc_nxt = cyc; assign bus_b.i_wb_stb_nxt = stb; assign bus_b.i_wb_wen_nxt = wen;
    assign bus_b.i_wb_sel_nxt = sel; assign bus_b.i_wb_dat_nxt = dat; assign bus_b.i_wb_adr_nxt = adr;
    assign bus_b.i_wb_cti_nxt = cti; assign bus_b.i_wb_ack = ack; assign bus_b.i_wb_err = err;
    assign bus_b.i_wb_dat = 32'h0;
    assign bus_c.i_wb_cyc_nxt = cyc; assign bus_c.i_wb_stb_nxt = stb; assign bus_c.i_wb_wen_nxt = wen;
    assign bus_c.i_wb_sel_nxt = sel; assign bus_c.i_wb_dat_nxt = dat; assign bus_c.i_wb_adr_nxt = adr;
    assign bus_c.i_wb_cti_nxt = cti; assign bus_c.i_wb_ack = ack; assign bus_c.i_wb_err = err;
    assign bus_c.i_wb_dat = 32'h0;

    zap_wb_arbiter_n #(.RR_EN(0), .LOCK_EN(0), .TIMEOUT(8)) dut_a (
        .i_clk(i_clk), .i_reset(i_reset), .wb(bus_a), .o_grant(grant_a), .o_timeout(tmo_a));
    zap_wb_arbiter_n #(.RR_EN(1), .LOCK_EN(0), .TIMEOUT(0)) dut_b (
        .i_clk(i_clk), .i_reset(i_reset), .wb(bus_b), .o_grant(grant_b), .o_timeout(tmo_b));
    zap_wb_arbiter_n #(.RR_EN(0), .LOCK_EN(1), .TIMEOUT(0)) dut_c (
        .i_clk(i_clk), .i_reset(i_reset), .wb(bus_c), .o_grant(grant_c), .o_timeout(tmo_c));

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        cyc = '0;
        stb = '0;
        ack = 1'b0;
        err = 1'b0;
        cti = {4{CTI_EOB}};
        tick();
        i_reset = 1'b0;
    endtask

    initial begin
        logic [3:0] rr_seq [4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
        logic [3:0] prev;
        do_reset();
        chk("rst_grant", grant_a, 4'b0001);
        chk("rst_stb", bus_a.o_wb_stb, 1'b0);
        chk("rst_cti", bus_a.o_wb_cti, 3'b111);
        chk("rst_tmo", tmo_a, 1'b0);

        // Fixed priority: masters 0 and 2 together, 2 wins and holds until its ACK.
        cyc = 4'b0101; stb = 4'b0101;
        #1 chk("fix_adr_nxt", bus_a.o_wb_adr_nxt, 32'ha0000002);
        tick();
        chk("fix_grant", grant_a, 4'b0100);
        chk("fix_adr", bus_a.o_wb_adr, 32'ha0000002);
        chk("fix_wen", bus_a.o_wb_wen, 1'b1);
        chk("fix_hold_nxt", bus_a.o_wb_adr_nxt, 32'ha0000002);
        tick();
        chk("fix_hold_grant", grant_a, 4'b0100);
        ack = 1'b1; cyc = 4'b0001; stb = 4'b0001;
        #1 chk("fix_ack", bus_a.o_wb_ack, 4'b0100);
        chk("fix_hand_nxt", bus_a.o_wb_adr_nxt, 32'ha0000000);
        tick();
        ack = 1'b0;
        chk("fix_grant0", grant_a, 4'b0001);
        chk("fix_adr0", bus_a.o_wb_adr, 32'ha0000000);

        // Round-robin: all four request continuously with single-beat ACKs.
        do_reset();
        cyc = 4'b1111; stb = 4'b1111;
        #1 chk("rr_adr_nxt", bus_b.o_wb_adr_nxt, 32'ha0000001);
        tick();
        chk("rr_grant1", grant_b, 4'b0010);
        prev = 4'b0010;
        ack = 1'b1;
        foreach (rr_seq[i]) begin
            #1 chk("rr_ack", bus_b.o_wb_ack, prev);
            tick();
            chk("rr_grant", grant_b, rr_seq[i]);
            prev = rr_seq[i];
        end
        ack = 1'b0;

        // Lock: master 1 keeps the bus for a 4-beat burst while master 3 waits.
        do_reset();
        cti = {4{CTI_BURST}};
        cyc = 4'b0010; stb = 4'b0010;
        tick();
        cyc = 4'b1010; stb = 4'b1010;
        for (int k = 1; k <= 4; k++) begin
            chk("lock_cti", bus_c.o_wb_cti, (k == 4) ? 3'b111 : 3'b010);
            chk("lock_grant", grant_c, 4'b0010);
            ack = 1'b1;
            if (k == 3) cti[5:3] = CTI_EOB;
            if (k == 4) begin
                cyc = 4'b1000;
                stb = 4'b1000;
            end
            #1 chk("lock_ack", bus_c.o_wb_ack, 4'b0010);
            tick();
        end
        ack = 1'b0;
        chk("lock_grant3", grant_c, 4'b1000);
        chk("lock_adr3", bus_c.o_wb_adr, 32'ha0000003);

        // Preemption without lock: master 3 takes over on master 0's ACK.
        do_reset();
        cyc = 4'b0001; stb = 4'b0001;
        tick();
        cyc = 4'b1001; stb = 4'b1001;
        #1 chk("pre_hold_nxt", bus_a.o_wb_adr_nxt, 32'ha0000000);
        tick();
        ack = 1'b1;
        #1 chk("pre_ack", bus_a.o_wb_ack, 4'b0001);
        chk("pre_adr_nxt", bus_a.o_wb_adr_nxt, 32'ha0000003);
        tick();
        ack = 1'b0;
        chk("pre_grant", grant_a, 4'b1000);
        chk("pre_adr", bus_a.o_wb_adr, 32'ha0000003);

        // Timeout: forced error in the 8th unacknowledged strobe cycle.
        do_reset();
        cyc = 4'b0100; stb = 4'b0100;
        tick();
        for (int c = 1; c <= 8; c++) begin
            chk("tmo_pulse", tmo_a, c == 8);
            chk("tmo_err", bus_a.o_wb_err, (c == 8) ? 4'b0100 : 4'b0000);
            tick();
        end
        do_reset();
        cyc = 4'b0100; stb = 4'b0100;
        tick();
        repeat (7) tick();
        ack = 1'b1;
        #1 chk("tmo_ack_ack", bus_a.o_wb_ack, 4'b0100);
        chk("tmo_ack_pulse", tmo_a, 1'b0);
        chk("tmo_ack_err", bus_a.o_wb_err, 4'b0000);
        ack = 1'b0;

        // Reset in the middle of an active strobe.
        do_reset();
        cti[8:6] = CTI_BURST;
        cyc = 4'b0100; stb = 4'b0100;
        tick();
        chk("mid_stb_pre", bus_a.o_wb_stb, 1'b1);
        i_reset = 1'b1;
        ack = 1'b1;
        #1 chk("mid_ack_in_rst", bus_a.o_wb_ack, 4'b0000);
        tick();
        i_reset = 1'b0;
        ack = 1'b0;
        #1 chk("mid_stb", bus_a.o_wb_stb, 1'b0);
        chk("mid_cyc", bus_a.o_wb_cyc, 1'b0);
        chk("mid_cti", bus_a.o_wb_cti, 3'b111);
        chk("mid_grant", grant_a, 4'b0001);
        chk("mid_ack", bus_a.o_wb_ack, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
